// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C target register block.
// Pure declarations: no logic, no latency, no flow control.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } i2c_state_e;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// 2-FF synchroniser plus stability filter for one I2C pad line; idles high.
// Latency 2 + FILT_LEN clk; no flow control, shorter pulses are dropped.
module i2c_line_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic line_o
);
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          line_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            line_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], line_i};
            // any return to the accepted level restarts the stability count
            if (sync_q[1] == line_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILT_LEN - 1)) begin
                line_q <= sync_q[1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte register file: pointer write, data write, sequential read.
// Bit decisions act on filtered SCL edges; no clock stretching, so no backpressure.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h3C,
    parameter int         REG_AW   = 4,
    parameter int         FILT_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i2c_scl_i,
    input  logic              i2c_sda_i,
    output logic              i2c_sda_o,
    output logic              i2c_sda_t,
    input  logic [REG_AW-1:0] i_host_addr,
    output logic [7:0]        o_host_data,
    output logic              o_wr_stb,
    output logic [REG_AW-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_busy
);
    localparam int DEPTH = 2 ** REG_AW;

    logic scl_f, sda_f, scl_p_q, sda_p_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk(clk), .rst_n(rst_n), .line_i(i2c_scl_i), .line_o(scl_f)
    );
    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk(clk), .rst_n(rst_n), .line_i(i2c_sda_i), .line_o(sda_f)
    );

    assign scl_rise  =  scl_f & ~scl_p_q;
    assign scl_fall  = ~scl_f &  scl_p_q;
    assign start_det =  scl_f &  scl_p_q &  sda_p_q & ~sda_f;
    assign stop_det  =  scl_f &  scl_p_q & ~sda_p_q &  sda_f;

    i2c_state_e        state_q, state_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic              sda_t_q, sda_t_d;
    logic              busy_q, busy_d;
    logic              rw_q, rw_d;
    logic              mack_q, mack_d;
    logic              we;
    logic [7:0]        rx_byte, rd_byte;
    logic [7:0]        regs_q [DEPTH];
    logic              wr_stb_q;
    logic [REG_AW-1:0] wr_addr_q;
    logic [7:0]        wr_data_q, host_data_q;

    assign rx_byte = {shift_q[6:0], sda_f};
    assign rd_byte = regs_q[ptr_q];

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        sda_t_d  = sda_t_q;
        busy_d   = busy_q;
        rw_d     = rw_q;
        mack_d   = mack_q;
        we       = 1'b0;
        if (start_det) begin
            state_d  = ST_ADDR;
            bitcnt_d = '0;
            sda_t_d  = 1'b1;
            busy_d   = 1'b0;
            mack_d   = 1'b0;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            sda_t_d = 1'b1;
            busy_d  = 1'b0;
            mack_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d  = rx_byte;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            if (state_q == ST_ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state_d = ST_ADDR_ACK;
                                    rw_d    = rx_byte[0];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = ST_IGNORE;
                                end
                            end else if (state_q == ST_PTR) begin
                                ptr_d   = rx_byte[REG_AW-1:0];
                                state_d = ST_PTR_ACK;
                            end else begin
                                we      = 1'b1;
                                ptr_d   = ptr_q + REG_AW'(1);
                                state_d = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                // ACK phase: first fall pulls SDA low, second fall ends the ACK
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (sda_t_q) begin
                            sda_t_d = 1'b0;
                        end else if (state_q == ST_ADDR_ACK && rw_q == I2C_RW_READ) begin
                            sda_t_d  = rd_byte[7];
                            shift_d  = {rd_byte[6:0], 1'b0};
                            bitcnt_d = 3'd1;
                            state_d  = ST_RDATA;
                        end else begin
                            sda_t_d = 1'b1;
                            state_d = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                        end
                    end
                end
                // bitcnt counts bits already driven; wrapping to 0 means all 8 are out
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 3'd0) begin
                            sda_t_d = 1'b1;
                            ptr_d   = ptr_q + REG_AW'(1);
                            state_d = ST_RDATA_ACK;
                        end else begin
                            sda_t_d  = shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                            bitcnt_d = bitcnt_q + 3'd1;
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_f == I2C_ACK) mack_d  = 1'b1;
                        else                  state_d = ST_IGNORE;
                    end else if (scl_fall && mack_q) begin
                        mack_d   = 1'b0;
                        sda_t_d  = rd_byte[7];
                        shift_d  = {rd_byte[6:0], 1'b0};
                        bitcnt_d = 3'd1;
                        state_d  = ST_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_p_q     <= 1'b1;
            sda_p_q     <= 1'b1;
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            sda_t_q     <= 1'b1;
            busy_q      <= 1'b0;
            rw_q        <= I2C_RW_WRITE;
            mack_q      <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            host_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            scl_p_q     <= scl_f;
            sda_p_q     <= sda_f;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sda_t_q     <= sda_t_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
            mack_q      <= mack_d;
            wr_stb_q    <= we;
            host_data_q <= regs_q[i_host_addr];
            if (we) begin
                regs_q[ptr_q] <= rx_byte;
                wr_addr_q     <= ptr_q;
                wr_data_q     <= rx_byte;
            end
        end
    end

    assign i2c_sda_o   = 1'b0;
    assign i2c_sda_t   = sda_t_q;
    assign o_host_data = host_data_q;
    assign o_wr_stb    = wr_stb_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-level I2C master on a wired-AND SDA line,
// with an array/queue model of the register file, pointer and write strobes.
module tb_i2c_target_regs;
    localparam int Q = 12;

    logic       clk = 1'b0;
    logic       rst_n, m_scl, m_sda, sda_o, sda_t, wr_stb, busy;
    logic       sda_line;
    logic [3:0] host_addr, wr_addr;
    logic [7:0] host_data, wr_data;

    always #5 clk = ~clk;
    assign sda_line = m_sda & sda_t;

    i2c_target_regs dut (
        .clk(clk), .rst_n(rst_n),
        .i2c_scl_i(m_scl), .i2c_sda_i(sda_line),
        .i2c_sda_o(sda_o), .i2c_sda_t(sda_t),
        .i_host_addr(host_addr), .o_host_data(host_data),
        .o_wr_stb(wr_stb), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_busy(busy)
    );

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  mregs [16];
    logic [3:0]  mptr;
    logic [7:0]  txq [$];
    logic [11:0] ev_q [$];

    always @(negedge clk) if (rst_n && wr_stb) ev_q.push_back({wr_addr, wr_data});

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q); m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b1; tick(Q);
    endtask

    task automatic write_bit(input logic b, input bit gl);
        m_sda = b; tick(Q); m_scl = 1'b1;
        if (gl) begin
            tick(Q / 2); m_scl = 1'b0; tick(2); m_scl = 1'b1; tick(2 * Q - Q / 2 - 2);
        end else begin
            tick(2 * Q);
        end
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic r);
        m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q);
        r = sda_line; tick(Q); m_scl = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input int gl, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i], gl == i);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            read_bit(r);
            d = {d[6:0], r};
        end
        write_bit(nack, 1'b0);
    endtask

    task automatic check_regfile(input string nm);
        for (int a = 0; a < 16; a++) begin
            @(negedge clk) host_addr = 4'(a);
            @(negedge clk);
            total++;
            if (host_data !== mregs[a]) begin
                bad++;
                $display("FAIL %s host_rd[%0d] got=%h exp=%h", nm, a, host_data, mregs[a]);
            end
        end
    endtask

    task automatic do_write(input logic [6:0] a7, input logic [7:0] p, input int gl, input string nm);
        logic        ack, exp_ack;
        logic [11:0] exp_q [$];
        bit          match;
        match   = (a7 == 7'h3C);
        exp_ack = match ? 1'b0 : 1'b1;
        ev_q.delete();
        i2c_start();
        write_byte({a7, 1'b0}, -1, ack);
        total++;
        if (ack !== exp_ack) begin bad++; $display("FAIL %s addr_ack got=%b exp=%b", nm, ack, exp_ack); end
        if (match) begin
            total++;
            if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_on got=%b exp=1", nm, busy); end
        end
        write_byte(p, -1, ack);
        total++;
        if (ack !== exp_ack) begin bad++; $display("FAIL %s ptr_ack got=%b exp=%b", nm, ack, exp_ack); end
        if (match) begin
            mptr = p[3:0];
            for (int i = 0; i < txq.size(); i++) begin
                write_byte(txq[i], (i == 0) ? gl : -1, ack);
                total++;
                if (ack !== 1'b0) begin bad++; $display("FAIL %s data%0d_ack got=%b exp=0", nm, i, ack); end
                mregs[mptr] = txq[i];
                exp_q.push_back({mptr, txq[i]});
                mptr++;
            end
        end
        i2c_stop();
        tick(20);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_off got=%b exp=0", nm, busy); end
        total++;
        if (ev_q.size() != exp_q.size()) begin
            bad++; $display("FAIL %s wr_stb_count got=%0d exp=%0d", nm, ev_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            total++;
            if (ev_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL %s wr_evt%0d got=%h exp=%h", nm, i, ev_q[i], exp_q[i]);
            end
        end
        check_regfile(nm);
    endtask

    task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n, input string nm);
        logic       ack;
        logic [7:0] d;
        ev_q.delete();
        i2c_start();
        if (set_ptr) begin
            write_byte(8'h78, -1, ack);
            total++;
            if (ack !== 1'b0) begin bad++; $display("FAIL %s waddr_ack got=%b exp=0", nm, ack); end
            write_byte(p, -1, ack);
            total++;
            if (ack !== 1'b0) begin bad++; $display("FAIL %s ptr_ack got=%b exp=0", nm, ack); end
            mptr = p[3:0];
            i2c_start();
        end
        write_byte(8'h79, -1, ack);
        total++;
        if (ack !== 1'b0) begin bad++; $display("FAIL %s raddr_ack got=%b exp=0", nm, ack); end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_on got=%b exp=1", nm, busy); end
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            total++;
            if (d !== mregs[mptr]) begin
                bad++; $display("FAIL %s rd%0d got=%h exp=%h", nm, i, d, mregs[mptr]);
            end
            mptr++;
        end
        i2c_stop();
        tick(20);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_off got=%b exp=0", nm, busy); end
        total++;
        if (ev_q.size() != 0) begin bad++; $display("FAIL %s stray_wr got=%0d exp=0", nm, ev_q.size()); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        total++;
        if (sda_t !== 1'b1)  begin bad++; $display("FAIL reset sda_t got=%b exp=1", sda_t); end
        total++;
        if (wr_stb !== 1'b0) begin bad++; $display("FAIL reset wr_stb got=%b exp=0", wr_stb); end
        total++;
        if (wr_addr !== 4'h0) begin bad++; $display("FAIL reset wr_addr got=%h exp=0", wr_addr); end
        total++;
        if (wr_data !== 8'h00) begin bad++; $display("FAIL reset wr_data got=%h exp=0", wr_data); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", busy); end
        total++;
        if (host_data !== 8'h00) begin bad++; $display("FAIL reset host_data got=%h exp=0", host_data); end
        rst_n = 1'b1;
        tick(5);
        check_regfile("reset");
    endtask

    task automatic test_write();
        txq = '{8'hA5, 8'h5A};
        do_write(7'h3C, 8'h02, -1, "write");
    endtask

    task automatic test_read();
        do_read(1'b1, 8'h02, 2, "read");
    endtask

    task automatic test_mismatch();
        txq.delete();
        do_write(7'h3D, 8'h11, -1, "mismatch");
    endtask

    task automatic test_wrap();
        txq = '{8'h11, 8'h22};
        do_write(7'h3C, 8'h0F, -1, "wrap");
    endtask

    task automatic test_glitch();
        txq = '{8'hC6, 8'h3B};
        do_write(7'h3C, 8'h08, 3, "glitch");
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_read($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(1, 3), "rnd_rd");
            end else begin
                txq.delete();
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) txq.push_back(8'($urandom));
                if ($urandom_range(0, 4) == 0)
                    do_write(7'h3C ^ 7'($urandom_range(1, 127)), 8'($urandom), -1, "rnd_wr_miss");
                else
                    do_write(7'h3C, 8'($urandom), -1, "rnd_wr");
            end
        end
    endtask

    task automatic test_reset_mid();
        logic       ack;
        logic [7:0] d;
        d = 8'h96;
        i2c_start();
        write_byte(8'h78, -1, ack);
        write_byte(8'h05, -1, ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i], 1'b0);
        total++;
        if (sda_t !== 1'b0) begin bad++; $display("FAIL rstmid ack_drive got=%b exp=0", sda_t); end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (sda_t !== 1'b1) begin bad++; $display("FAIL rstmid sda_release got=%b exp=1", sda_t); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rstmid busy got=%b exp=0", busy); end
        m_scl = 1'b1; tick(5);
        m_sda = 1'b1; tick(5);
        rst_n = 1'b1;
        tick(10);
        for (int a = 0; a < 16; a++) mregs[a] = '0;
        mptr = '0;
        check_regfile("rstmid");
        do_read(1'b0, 8'h00, 2, "rstmid_rd");
        txq = '{8'hC3};
        do_write(7'h3C, 8'h07, -1, "rstmid_wr");
    endtask

    initial begin
        rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1; host_addr = '0;
        for (int a = 0; a < 16; a++) mregs[a] = '0;
        mptr = '0;
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_wrap();
        test_glitch();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
